// File: rtl/alu_operand_reg_mux.sv
// alu_operand_reg_mux: registered ALU A-operand selector with optional <<2 and valid/ready output stage
module alu_operand_reg_mux #(
  parameter int WIDTH = 32,
  parameter int NSRC = 4,
  parameter int SEL_W = 2,
  parameter bit CONST_EN = 1,
  parameter int CONST_VAL = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SEL_W-1:0]      selector,
  input  logic [NSRC*WIDTH-1:0] data_in,
  input  logic                  shift2,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      data_out,
  output logic                  sel_err
);
  typedef enum logic {EMPTY, FULL} state_t;
  localparam logic [WIDTH-1:0] const_v = WIDTH'(CONST_VAL);
  state_t state, state_n;
  logic [WIDTH-1:0] sel_val, shifted;
  logic out_of_range, capture;
  // source mux; indices with no source fall through to zero, top index may be the constant
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NSRC; i++)
      if (selector == SEL_W'(i))
        sel_val = (CONST_EN && i == NSRC - 1) ? const_v : data_in[i*WIDTH +: WIDTH];
  end
  assign out_of_range = {1'b0, selector} >= (SEL_W+1)'(NSRC);
  assign shifted = shift2 ? {sel_val[WIDTH-3:0], 2'b00} : sel_val;
  assign out_valid = state == FULL;
  assign in_ready = !out_valid || out_ready;
  assign capture = in_valid && in_ready;
  // next state: a capture always fills, a consume without capture drains
  always_comb begin
    state_n = capture ? FULL : (out_ready ? EMPTY : state);
  end
  // state register
  always_ff @(posedge clk) begin
    state <= reset ? EMPTY : state_n;
  end
  // operand and error flag only change on capture
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
      sel_err <= 1'b0;
    end else if (capture) begin
      data_out <= shifted;
      sel_err <= out_of_range;
    end
  end
endmodule

// File: tb/tb_alu_operand_reg_mux.sv
// tb_alu_operand_reg_mux: directed table-driven bench for the registered operand selector
module tb_alu_operand_reg_mux;
  logic clk = 0, reset = 1;
  logic [1:0] selector = '0;
  logic [127:0] data_in = '0;
  logic [95:0] data_in3 = '0;
  logic shift2 = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, sel_err;
  logic [31:0] data_out;
  logic in_ready3, out_valid3, sel_err3;
  logic [31:0] data_out3;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  alu_operand_reg_mux dut (
    .clk(clk), .reset(reset), .selector(selector), .data_in(data_in), .shift2(shift2),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .sel_err(sel_err)
  );

  alu_operand_reg_mux #(.NSRC(3), .SEL_W(2)) dut3 (
    .clk(clk), .reset(reset), .selector(selector), .data_in(data_in3), .shift2(shift2),
    .in_valid(in_valid), .in_ready(in_ready3), .out_valid(out_valid3), .out_ready(out_ready),
    .data_out(data_out3), .sel_err(sel_err3)
  );

  typedef struct {
    logic [1:0] sel;
    logic sh, iv, ordy;
    logic [127:0] din;
    logic e_ir, e_ov;
    logic [31:0] e_do;
    logic e_err;
  } vec_t;

  localparam logic [127:0] D = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] DC = {32'h44444444, 32'h33333333, 32'h22222222, 32'hC0000003};
  localparam logic [127:0] DA = {4{32'hAAAAAAAA}};
  localparam logic [95:0] D3 = {32'h33333333, 32'h22222222, 32'h11111111};

  vec_t tv[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] s, input logic sh, input logic iv, input logic ordy);
    selector = s;
    shift2 = sh;
    in_valid = iv;
    out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = '{2'd1, 0, 1, 1, D,  1, 1, 32'h22222222, 0};
    tv[1]  = '{2'd3, 0, 1, 1, D,  1, 1, 32'h00000004, 0};
    tv[2]  = '{2'd3, 1, 1, 1, D,  1, 1, 32'h00000010, 0};
    tv[3]  = '{2'd0, 1, 1, 1, DC, 1, 1, 32'h0000000C, 0};
    tv[4]  = '{2'd2, 0, 0, 1, D,  1, 0, 32'h0000000C, 0};
    tv[5]  = '{2'd0, 0, 0, 0, D,  1, 0, 32'h0000000C, 0};
    tv[6]  = '{2'd1, 0, 1, 0, D,  1, 1, 32'h22222222, 0};
    tv[7]  = '{2'd2, 0, 1, 0, DA, 0, 1, 32'h22222222, 0};
    tv[8]  = '{2'd3, 1, 1, 0, DA, 0, 1, 32'h22222222, 0};
    tv[9]  = '{2'd0, 0, 1, 0, DA, 0, 1, 32'h22222222, 0};
    tv[10] = '{2'd2, 0, 1, 1, D,  1, 1, 32'h33333333, 0};
    tv[11] = '{2'd0, 0, 0, 1, D,  1, 0, 32'h33333333, 0};

    tick();
    tick();
    #1;
    reset = 0;
    #1;
    chk("rst_data", data_out, 0);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_err", {31'd0, sel_err}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);

    for (int i = 0; i < 12; i++) begin
      data_in = tv[i].din;
      drive(tv[i].sel, tv[i].sh, tv[i].iv, tv[i].ordy);
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tv[i].e_ir});
      tick();
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, tv[i].e_ov});
      chk($sformatf("v%0d_data", i), data_out, tv[i].e_do);
      chk($sformatf("v%0d_err", i), {31'd0, sel_err}, {31'd0, tv[i].e_err});
    end

    data_in = D;
    data_in3 = D3;
    drive(2'd1, 0, 1, 0);
    tick();
    chk("mid_full_data", data_out, 32'h22222222);
    reset = 1;
    drive(2'd2, 0, 1, 0);
    tick();
    reset = 0;
    drive(2'd0, 0, 0, 0);
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 1);

    drive(2'd2, 0, 1, 1);
    tick();
    chk("n3_const_data", data_out3, 32'h00000004);
    drive(2'd3, 0, 1, 1);
    tick();
    chk("n3_oor_data", data_out3, 0);
    chk("n3_oor_err", {31'd0, sel_err3}, 1);
    chk("n3_oor_valid", {31'd0, out_valid3}, 1);
    drive(2'd0, 0, 1, 0);
    chk("n3_bp_in_ready", {31'd0, in_ready3}, 0);
    tick();
    chk("n3_bp_err_held", {31'd0, sel_err3}, 1);
    chk("n3_bp_data_held", data_out3, 0);
    drive(2'd0, 0, 1, 1);
    tick();
    chk("n3_sel0_data", data_out3, 32'h11111111);
    chk("n3_sel0_err", {31'd0, sel_err3}, 0);
    drive(2'd1, 1, 1, 1);
    tick();
    chk("n3_sel1_shift", data_out3, 32'h88888888);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
